// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction-in, ALU-drive and result-out signals of alu_issue_ctrl.
// Both handshakes transfer on valid & ready at a rising clk edge; valid never waits on ready.
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic [12:0] in_data;
  logic        in_ready;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_op;
  logic [3:0]  alu_res;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_data;
  logic [3:0]  res_op;
  logic        res_zero;
  logic [7:0]  op_count;
  logic        busy;

  modport slave (
    input  in_valid, in_data, alu_res, res_ready,
    output in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op, res_zero,
           op_count, busy
  );

  modport master (
    output in_valid, in_data, alu_res, res_ready,
    input  in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op, res_zero,
           op_count, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue front end for a 4-bit combinational ALU: instruction FIFO, IDLE/ISSUE/HOLD
// sequencer, result capture with optional chaining of the last result into operand A.
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  bus,
  output logic [1:0]       dbg_state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [12:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [3:0]      alu_a_q, alu_b_q, alu_op_q;
  logic [3:0]      res_data_q, res_op_q, last_res_q;
  logic [7:0]      op_count_q;

  logic            fifo_empty, push, pop, capture;
  logic [12:0]     head;

  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign push       = bus.in_valid & bus.in_ready & ~rst;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage is not reset: the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      res_data_q <= '0;
      res_op_q   <= '0;
      last_res_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      // Chained ops take the last captured result, which ISSUE always updates before any later load.
      if (pop) begin
        alu_op_q <= head[11:8];
        alu_b_q  <= head[3:0];
        alu_a_q  <= head[12] ? last_res_q : head[7:4];
      end
      if (capture) begin
        res_data_q <= bus.alu_res;
        res_op_q   <= alu_op_q;
        last_res_q <= bus.alu_res;
        op_count_q <= op_count_q + 8'd1;
      end
    end
  end

  assign bus.in_ready  = (count_q != FULL_CNT);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.res_valid = (state_q == HOLD);
  assign bus.res_data  = res_data_q;
  assign bus.res_op    = res_op_q;
  assign bus.res_zero  = (res_data_q == 4'd0);
  assign bus.op_count  = op_count_q;
  assign bus.busy      = (state_q != IDLE) || !fifo_empty;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a small reference ALU and a result scoreboard.
module tb_alu_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_pass = 0;
  int         cycle = 0;
  int         acc_cnt = 0;
  int         pushes_since_rst = 0;
  logic [3:0] model_last = 4'd0;
  logic [7:0] exp_q[$];
  int         hs_times[$];

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [3:0] alu_model(input logic [3:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a ^ b ^ op;
    endcase
  endfunction

  always_comb bus.alu_res = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: expectations are formed when a push is about to be accepted,
  // and compared when a result handshake is about to happen.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_last = 4'd0;
      pushes_since_rst = 0;
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        hs_times.push_back(cycle);
        if (exp_q.size() == 0) check("sb_unexpected_result", 1, 0);
        else check("sb_result", {bus.res_op, bus.res_data}, exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        logic [3:0] a_eff, r;
        a_eff = bus.in_data[12] ? model_last : bus.in_data[7:4];
        r = alu_model(bus.in_data[11:8], a_eff, bus.in_data[3:0]);
        model_last = r;
        exp_q.push_back({bus.in_data[11:8], r});
        acc_cnt++;
        pushes_since_rst++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [12:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
    check(name, bus.res_valid, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    check(name, bus.busy, 0);
  endtask

  typedef struct packed {
    logic       chain;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_a;
    logic [3:0] exp_res;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int seen;
    vecs[0] = '{1'b0, 4'd1,  4'd3, 4'd1,  4'd3,  4'd4};
    vecs[1] = '{1'b1, 4'd1,  4'd9, 4'd2,  4'd4,  4'd6};
    vecs[2] = '{1'b0, 4'd2,  4'd0, 4'd1,  4'd0,  4'd15};
    vecs[3] = '{1'b0, 4'd0,  4'd5, 4'd10, 4'd5,  4'd0};
    vecs[4] = '{1'b1, 4'd4,  4'd7, 4'd15, 4'd0,  4'd15};
    vecs[5] = '{1'b1, 4'd1,  4'd2, 4'd1,  4'd15, 4'd0};
    vecs[6] = '{1'b0, 4'd3,  4'd9, 4'd6,  4'd9,  4'd15};
    vecs[7] = '{1'b0, 4'd15, 4'd2, 4'd4,  4'd2,  4'd9};
    vecs[8] = '{1'b1, 4'd2,  4'd0, 4'd3,  4'd9,  4'd6};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_res_valid", bus.res_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_alu_regs", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
    check("rst_res", {bus.res_data, bus.res_op}, 0);
    check("rst_res_zero", bus.res_zero, 1);
    check("rst_op_count", bus.op_count, 0);
    check("rst_state", dbg_state, 0);

    // Single op, exact latency: push at edge k, load at k+1, capture at k+2.
    push1({1'b0, 4'b0001, 4'b0011, 4'b0001});
    check("single_busy_k", bus.busy, 1);
    check("single_valid_k", bus.res_valid, 0);
    tick();
    check("single_alu_op", bus.alu_op, 1);
    check("single_alu_a", bus.alu_a, 3);
    check("single_alu_b", bus.alu_b, 1);
    check("single_valid_k1", bus.res_valid, 0);
    tick();
    check("single_valid_k2", bus.res_valid, 1);
    check("single_res_data", bus.res_data, 4);
    check("single_res_op", bus.res_op, 1);
    check("single_op_count", bus.op_count, 1);
    tick();
    check("single_hold_stable", {bus.res_valid, bus.res_data}, {1'b1, 4'd4});
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    tick();
    check("single_valid_drop", bus.res_valid, 0);

    for (int i = 0; i < 9; i++) begin
      push1({vecs[i].chain, vecs[i].op, vecs[i].a, vecs[i].b});
      wait_valid($sformatf("vec%0d_timeout", i));
      check($sformatf("vec%0d_alu_a", i), bus.alu_a, vecs[i].exp_a);
      check($sformatf("vec%0d_res_data", i), bus.res_data, vecs[i].exp_res);
      check($sformatf("vec%0d_res_op", i), bus.res_op, vecs[i].op);
      check($sformatf("vec%0d_res_zero", i), bus.res_zero, vecs[i].exp_res == 4'd0);
      check($sformatf("vec%0d_op_count", i), bus.op_count, pushes_since_rst % 256);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
    end

    // Stream random ops until exactly 256 results have been captured since reset.
    begin
      int target, n;
      target = 256 - pushes_since_rst;
      acc_cnt = 0;
      n = 0;
      bus.res_ready = 1'b1;
      bus.in_valid  = 1'b1;
      while (acc_cnt < target && n < 3000) begin
        bus.in_data = 13'($urandom_range(0, 8191));
        tick();
        n++;
      end
      bus.in_valid = 1'b0;
      check("wrap_pushes", acc_cnt, target);
      wait_idle("wrap_drain");
      check("wrap_op_count", bus.op_count, 0);
      check("wrap_sb_empty", exp_q.size(), 0);
    end

    // Backpressure: one result held plus a full FIFO, then drain at one per two cycles.
    bus.res_ready = 1'b0;
    acc_cnt = 0;
    bus.in_valid = 1'b1;
    repeat (12) begin
      bus.in_data = 13'($urandom_range(0, 8191));
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", acc_cnt, 5);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_res_valid", bus.res_valid, 1);
    hs_times.delete();
    bus.res_ready = 1'b1;
    for (int n = 0; n < 30 && hs_times.size() < 5; n++) tick();
    check("bp_drained", hs_times.size(), 5);
    seen = 0;
    for (int i = 1; i < hs_times.size(); i++)
      if (hs_times[i] - hs_times[i-1] != 2) seen++;
    check("bp_spacing", seen, 0);
    wait_idle("bp_idle");
    check("bp_sb_empty", exp_q.size(), 0);

    // Simultaneous push and pop in HOLD keeps occupancy: only two more fit afterwards.
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (3) begin
      bus.in_data = 13'($urandom_range(0, 8191));
      tick();
    end
    bus.in_valid = 1'b0;
    wait_valid("sim_hold");
    acc_cnt = 0;
    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 13'($urandom_range(0, 8191));
    tick();
    bus.res_ready = 1'b0;
    repeat (6) begin
      bus.in_data = 13'($urandom_range(0, 8191));
      tick();
    end
    bus.in_valid = 1'b0;
    check("sim_accepted", acc_cnt, 3);
    check("sim_full", bus.in_ready, 0);
    bus.res_ready = 1'b1;
    wait_idle("sim_drain");
    check("sim_sb_empty", exp_q.size(), 0);

    // Reset while holding a result with three queued behind it.
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (4) begin
      bus.in_data = 13'($urandom_range(0, 8191));
      tick();
    end
    bus.in_valid = 1'b0;
    wait_valid("rh_hold");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rh_res_valid", bus.res_valid, 0);
    check("rh_busy", bus.busy, 0);
    check("rh_in_ready", bus.in_ready, 1);
    check("rh_op_count", bus.op_count, 0);
    check("rh_regs", {bus.alu_a, bus.alu_b, bus.alu_op, bus.res_data, bus.res_op}, 0);
    check("rh_res_zero", bus.res_zero, 1);
    bus.res_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.res_valid) seen++;
    end
    check("rh_no_output", seen, 0);
    check("rh_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
